// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - four-digit seven-segment scan controller with frame-synchronous double buffering
//
// Purpose:
//   Time-multiplexes four 4-bit decoder codes onto one shared decoder input.
//   Each digit slot lasts REFRESH_DIV clocks. New frame data is held in a
//   pending buffer and moved to the active buffer only at a frame boundary,
//   so a frame never shows a mix of old and new codes.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (2..65535)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_valid  new frame data offered
//   load_ready  pending buffer empty, a load can be accepted
//   load_data   four codes, [3:0] = digit 0 (rightmost), [15:12] = digit 3
//   ssd_in      code for the active digit (to the 7-segment decoder)
//   ssd_an      active-low digit enable, exactly one bit low
//   frame_done  one-cycle pulse on the last cycle of each frame
//
// Optional feature:
//   SSD_LZ_BLANK_EN  when defined, leading zeros on digits 3..1 show as blank (4'hD)

module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic [3:0]  ssd_in,
  output logic [3:0]  ssd_an,
  output logic        frame_done
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] TC = DW'(REFRESH_DIV - 1);
  localparam logic [15:0] BLANK_ALL = 16'hDDDD;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_full_q, pend_full_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    in_q, in_d;

  logic tc;
  logic frame_end;
  logic transfer;
  logic accept;

  // Select the code of one digit; with blanking enabled, a zero digit above
  // digit 0 is blanked while every higher digit is zero or already blank.
  function automatic logic [3:0] disp_code(input logic [15:0] codes,
                                           input logic [1:0]  sel);
    logic [3:0] res;
`ifdef SSD_LZ_BLANK_EN
    logic       quiet;
    logic [3:0] c;
`endif
    res = codes[4*sel +: 4];
`ifdef SSD_LZ_BLANK_EN
    quiet = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      c = codes[4*k +: 4];
      if ((int'(sel) == k) && quiet && (c == 4'h0)) begin
        res = 4'hD;
      end
      // quiet must describe only the digits above k when k is tested.
      quiet = quiet && ((c == 4'h0) || (c == 4'hD) || (c == 4'hE));
    end
`endif
    return res;
  endfunction

  always_comb begin
    tc          = (div_q == TC);
    frame_end   = tc && (slot_q == 2'd3);
    transfer    = frame_end && pend_full_q;
    // A full pending buffer blocks loads, which also keeps a boundary
    // transfer and a new capture from ever landing in the same cycle.
    accept      = load_valid && !pend_full_q;

    div_d       = tc ? '0 : div_q + DW'(1);
    slot_d      = tc ? slot_q + 2'd1 : slot_q;

    active_d    = transfer ? pending_q : active_q;
    pending_d   = accept ? load_data : pending_q;
    pend_full_d = pend_full_q;
    if (transfer) begin
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end

    // Outputs are registered from the next-state slot and buffer so they
    // change on the same edge as slot_q, with new data starting at slot 0.
    an_d = ~(4'b0001 << slot_d);
    in_d = disp_code(active_d, slot_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      slot_q      <= 2'd0;
      active_q    <= BLANK_ALL;
      pending_q   <= BLANK_ALL;
      pend_full_q <= 1'b0;
      an_q        <= 4'b1110;
      in_q        <= 4'hD;
    end else begin
      div_q       <= div_d;
      slot_q      <= slot_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      an_q        <= an_d;
      in_q        <= in_d;
    end
  end

  assign load_ready = !pend_full_q;
  assign frame_done = frame_end;
  assign ssd_an     = an_q;
  assign ssd_in     = in_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - randomized self-checking bench for ssd_scan_ctrl against a frame-level model

module tb_ssd_scan_ctrl;

  localparam int RD = 4;
  localparam int FRAME = 4 * RD;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  ssd_in;
  logic [3:0]  ssd_an;
  logic        frame_done;

  ssd_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .ssd_in     (ssd_in),
    .ssd_an     (ssd_an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: time since reset release decides slot and boundary; buffers are
  // tracked as whole frame words.
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  bit          m_full;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, m_t, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_code(input logic [15:0] w, input int s);
    logic [3:0] c;
    c = w[4*s +: 4];
`ifdef SSD_LZ_BLANK_EN
    begin
      int lead;
      logic [3:0] d;
      lead = -1;
      for (int k = 0; k < 4; k++) begin
        d = w[4*k +: 4];
        if (d != 4'h0 && d != 4'hD && d != 4'hE) lead = k;
      end
      if (s != 0 && c == 4'h0 && s > lead) c = 4'hD;
    end
`endif
    return c;
  endfunction

  function automatic int m_slot();
    return (m_t / RD) % 4;
  endfunction

  task automatic model_reset();
    m_t       = 0;
    m_active  = 16'hDDDD;
    m_pending = 16'hDDDD;
    m_full    = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    logic [3:0] an_exp;
    an_exp = ~(4'b0001 << m_slot());
    check({pfx, "_an"}, 16'(ssd_an), 16'(an_exp));
    check({pfx, "_in"}, 16'(ssd_in), 16'(exp_code(m_active, m_slot())));
    check({pfx, "_ready"}, 16'(load_ready), 16'(!m_full));
    check({pfx, "_fdone"}, 16'(frame_done), 16'((m_t % FRAME) == FRAME - 1));
  endtask

  // One clock: present inputs, advance the model at the edge, check at negedge.
  task automatic step(input logic lv, input logic [15:0] ld);
    bit boundary;
    load_valid = lv;
    load_data  = ld;
    @(posedge clk);
    boundary = ((m_t % FRAME) == FRAME - 1);
    if (boundary && m_full) begin
      m_active = m_pending;
      m_full   = 1'b0;
    end else if (lv && !m_full) begin
      m_pending = ld;
      m_full    = 1'b1;
    end
    m_t++;
    @(negedge clk);
    check_outputs("scan");
  endtask

  logic [15:0] pick;
  logic [15:0] table_w [6];

  initial begin
    table_w[0] = 16'h0070;
    table_w[1] = 16'hF005;
    table_w[2] = 16'h0000;
    table_w[3] = 16'hD0A0;
    table_w[4] = 16'h00E1;
    table_w[5] = 16'hC0B0;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    model_reset();
    #12;
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan, then 1234 offered at cycle 5.
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0);
    step(1'b1, 16'h1234);
    for (int i = 0; i < 40; i++) step(1'b0, 16'h0);

    // 5678 then 9ABC held while pending is full, across a boundary.
    step(1'b1, 16'h5678);
    for (int i = 0; i < 40; i++) step(1'b1, 16'h9ABC);
    for (int i = 0; i < 40; i++) step(1'b0, 16'h0);

    // Blanking patterns.
    step(1'b1, 16'h0070);
    for (int i = 0; i < 36; i++) step(1'b0, 16'h0);
    step(1'b1, 16'hF005);
    for (int i = 0; i < 36; i++) step(1'b0, 16'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      pick = ($urandom_range(0, 1) == 0) ? table_w[$urandom_range(0, 5)] : 16'($urandom);
      step($urandom_range(0, 3) == 0, pick);
    end

    // Reset mid slot 2 with 4321 pending.
    for (int i = 0; i < 64 && (m_full || (m_t % FRAME) != 1); i++) step(1'b0, 16'h0);
    check("pre_load_ready", 16'(load_ready), 16'(1));
    step(1'b1, 16'h4321);
    for (int i = 0; i < 64 && (m_t % FRAME) != 2 * RD + 1; i++) step(1'b0, 16'h0);
    check("pre_rst_full", 16'(load_ready), 16'(0));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 48; i++) step(1'b0, 16'h0);
    step(1'b1, 16'h0A5F);
    for (int i = 0; i < 40; i++) step(1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
